// File: rtl/fnd_source_scheduler_if.sv
// ============================================================================
// Module   : fnd_source_scheduler_if
// Brief    : Source-side and FND-side signal bundle of the source scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface fnd_source_scheduler_if;
    logic [3:0]  i_src_valid;
    logic [95:0] i_src_data;
    logic [3:0]  i_src_hm;
    logic [3:0]  i_src_alert;
    logic        i_btn_next;
    logic        i_btn_mode;
    logic [23:0] o_fnd_in_data;
    logic        o_sel_display;
    logic [1:0]  o_src_idx;
    logic        o_mode;
    logic        o_alert_active;
    logic        o_blank;

    modport master (
        output i_src_valid, i_src_data, i_src_hm, i_src_alert, i_btn_next, i_btn_mode,
        input  o_fnd_in_data, o_sel_display, o_src_idx, o_mode, o_alert_active, o_blank
    );

    modport slave (
        input  i_src_valid, i_src_data, i_src_hm, i_src_alert, i_btn_next, i_btn_mode,
        output o_fnd_in_data, o_sel_display, o_src_idx, o_mode, o_alert_active, o_blank
    );
endinterface

`default_nettype wire

// File: rtl/fnd_source_scheduler.sv
// ============================================================================
// Module   : fnd_source_scheduler
// Brief    : Shares one 4-digit FND path between four sources (auto rotate,
//            manual stepping, alert pre-emption with a fixed hold time).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fnd_source_scheduler #(
    parameter int TICK_DIV = 100_000,
    parameter int DWELL_MS = 2000,
    parameter int ALERT_MS = 3000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fnd_source_scheduler_if.slave  bus
);

    localparam int c_TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DWELL_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int c_ALERT_W = (ALERT_MS > 1) ? $clog2(ALERT_MS) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_MS - 1);
    localparam logic [c_ALERT_W-1:0] c_ALERT_LAST = c_ALERT_W'(ALERT_MS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHOW  = 2'd1;
    localparam logic [1:0] c_ST_ALERT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           r_cur;
    logic                 r_mode;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_ALERT_W-1:0] r_atmr;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [3:0]           r_alert_q;
    logic [23:0]          r_fnd;
    logic                 r_sel;
    logic                 r_blank;
    logic                 r_alert_act;

    logic [1:0]           w_nxt_state;
    logic [1:0]           w_nxt_cur;
    logic                 w_nxt_mode;
    logic [c_DWELL_W-1:0] w_nxt_dwell;
    logic [c_ALERT_W-1:0] w_nxt_atmr;
    logic [23:0]          w_fnd_nxt;
    logic                 w_sel_nxt;

    logic                 w_tick;
    logic [3:0]           w_alert_lvl;
    logic [3:0]           w_rise;
    logic                 w_any_valid;
    logic                 w_cur_valid;
    logic [1:0]           w_nv;
    logic [1:0]           w_low_valid;
    logic [1:0]           w_low_rise;
    logic [23:0]          w_word [4];

    // Round-robin search cur+1..cur+3; falls back to cur when nothing else is valid.
    function automatic logic [1:0] f_next_valid(input logic [1:0] cur, input logic [3:0] v);
        logic [1:0] res;
        res = cur;
        for (int i = 3; i >= 1; i--) begin
            if (v[cur + 2'(i)]) res = cur + 2'(i);
        end
        return res;
    endfunction

    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) res = 2'(i);
        end
        return res;
    endfunction

    generate
        for (genvar k = 0; k < 4; k++) begin : g_word
            assign w_word[k] = bus.i_src_data[24*k +: 24];
        end
    endgenerate

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    assign w_alert_lvl = bus.i_src_alert & bus.i_src_valid;
    assign w_rise      = w_alert_lvl & ~r_alert_q;
    assign w_any_valid = |bus.i_src_valid;
    assign w_cur_valid = bus.i_src_valid[r_cur];
    assign w_nv        = f_next_valid(r_cur, bus.i_src_valid);
    assign w_low_valid = f_lowest(bus.i_src_valid);
    assign w_low_rise  = f_lowest(w_rise);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cur       <= 2'd0;
            r_mode      <= 1'b0;
            r_dwell     <= '0;
            r_atmr      <= '0;
            r_tick_cnt  <= '0;
            r_alert_q   <= 4'd0;
            r_fnd       <= 24'd0;
            r_sel       <= 1'b0;
            r_blank     <= 1'b1;
            r_alert_act <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cur       <= w_nxt_cur;
            r_mode      <= w_nxt_mode;
            r_dwell     <= w_nxt_dwell;
            r_atmr      <= w_nxt_atmr;
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_alert_q   <= w_alert_lvl;
            r_fnd       <= w_fnd_nxt;
            r_sel       <= w_sel_nxt;
            r_blank     <= (w_nxt_state == c_ST_IDLE);
            r_alert_act <= (w_nxt_state == c_ST_ALERT);
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur;
        w_nxt_mode  = r_mode;
        w_nxt_dwell = r_dwell;
        w_nxt_atmr  = r_atmr;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_rise) begin
                    w_nxt_state = c_ST_ALERT;
                    w_nxt_cur   = w_low_rise;
                    w_nxt_atmr  = '0;
                end else if (w_any_valid) begin
                    w_nxt_state = c_ST_SHOW;
                    w_nxt_cur   = w_low_valid;
                    w_nxt_dwell = '0;
                end
            end
            c_ST_SHOW: begin
                if (|w_rise) begin
                    w_nxt_state = c_ST_ALERT;
                    w_nxt_cur   = w_low_rise;
                    w_nxt_atmr  = '0;
                end else if (!w_cur_valid) begin
                    if (!w_any_valid) begin
                        w_nxt_state = c_ST_IDLE;
                    end else begin
                        w_nxt_cur   = w_nv;
                        w_nxt_dwell = '0;
                    end
                end else begin
                    if (bus.i_btn_mode) begin
                        w_nxt_mode  = ~r_mode;
                        w_nxt_dwell = '0;
                    end
                    if (bus.i_btn_next) begin
                        w_nxt_cur   = w_nv;
                        w_nxt_dwell = '0;
                    end else if (!bus.i_btn_mode && !r_mode && w_tick) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            w_nxt_cur   = w_nv;
                            w_nxt_dwell = '0;
                        end else begin
                            w_nxt_dwell = r_dwell + 1'b1;
                        end
                    end
                end
            end
            c_ST_ALERT: begin
                // Buttons and further rises are deliberately not looked at here.
                if (!w_cur_valid) begin
                    if (!w_any_valid) begin
                        w_nxt_state = c_ST_IDLE;
                    end else begin
                        w_nxt_state = c_ST_SHOW;
                        w_nxt_cur   = w_nv;
                        w_nxt_dwell = '0;
                    end
                end else if (w_tick) begin
                    if (r_atmr == c_ALERT_LAST) begin
                        w_nxt_state = c_ST_SHOW;
                        w_nxt_dwell = '0;
                        w_nxt_atmr  = '0;
                    end else begin
                        w_nxt_atmr = r_atmr + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
            end
        endcase
    end

    // Display word blanks as soon as the scheduler is entering or sitting in IDLE.
    always_comb begin
        w_fnd_nxt = 24'd0;
        w_sel_nxt = 1'b0;
        if ((r_state != c_ST_IDLE) && (w_nxt_state != c_ST_IDLE)) begin
            w_fnd_nxt = w_word[r_cur];
            w_sel_nxt = bus.i_src_hm[r_cur];
        end
    end

    assign bus.o_fnd_in_data  = r_fnd;
    assign bus.o_sel_display  = r_sel;
    assign bus.o_src_idx      = r_cur;
    assign bus.o_mode         = r_mode;
    assign bus.o_alert_active = r_alert_act;
    assign bus.o_blank        = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_fnd_source_scheduler.sv
// ============================================================================
// Module   : tb_fnd_source_scheduler
// Brief    : Directed scenarios plus random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fnd_source_scheduler;

    localparam int TICK_DIV = 10;
    localparam int DWELL_MS = 3;
    localparam int ALERT_MS = 5;
    localparam int c_IDLE   = 0;
    localparam int c_SHOW   = 1;
    localparam int c_ALERT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fnd_source_scheduler_if bus ();

    fnd_source_scheduler #(
        .TICK_DIV (TICK_DIV),
        .DWELL_MS (DWELL_MS),
        .ALERT_MS (ALERT_MS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] f_word(input int k);
        return 24'(24'h11111 * (k + 1));
    endfunction

    // ---------------- reference model ----------------
    int          m_where, m_cur, m_mode, m_dwell, m_atmr, m_n;
    bit [3:0]    m_prev;
    logic [23:0] m_fnd;
    bit          m_sel;

    function automatic int f_lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int f_next(input int c, input bit [3:0] v);
        for (int i = 1; i < 4; i++) if (v[(c + i) % 4]) return (c + i) % 4;
        return c;
    endfunction

    task automatic model_reset();
        m_where = c_IDLE; m_cur = 0; m_mode = 0; m_dwell = 0; m_atmr = 0;
        m_n = 0; m_prev = 4'd0; m_fnd = 24'd0; m_sel = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] v, lvl, rise;
        bit       tick;
        int       old_where, old_cur;
        v    = bus.i_src_valid;
        tick = (m_n % TICK_DIV) == TICK_DIV - 1;
        m_n++;
        lvl    = bus.i_src_alert & v;
        rise   = lvl & ~m_prev;
        m_prev = lvl;
        old_where = m_where;
        old_cur   = m_cur;
        if (m_where == c_IDLE) begin
            if (rise != 0)   begin m_where = c_ALERT; m_cur = f_lowest(rise); m_atmr = 0; end
            else if (v != 0) begin m_where = c_SHOW; m_cur = f_lowest(v); m_dwell = 0; end
        end else if (m_where == c_SHOW) begin
            if (rise != 0) begin
                m_where = c_ALERT; m_cur = f_lowest(rise); m_atmr = 0;
            end else if (!v[m_cur]) begin
                if (v == 0) m_where = c_IDLE;
                else begin m_cur = f_next(m_cur, v); m_dwell = 0; end
            end else if (bus.i_btn_mode || bus.i_btn_next) begin
                if (bus.i_btn_mode) m_mode = 1 - m_mode;
                if (bus.i_btn_next) m_cur = f_next(m_cur, v);
                m_dwell = 0;
            end else if (m_mode == 0 && tick) begin
                m_dwell++;
                if (m_dwell == DWELL_MS) begin m_dwell = 0; m_cur = f_next(m_cur, v); end
            end
        end else begin
            if (!v[m_cur]) begin
                if (v == 0) m_where = c_IDLE;
                else begin m_where = c_SHOW; m_cur = f_next(m_cur, v); m_dwell = 0; end
            end else if (tick) begin
                m_atmr++;
                if (m_atmr == ALERT_MS) begin m_where = c_SHOW; m_atmr = 0; m_dwell = 0; end
            end
        end
        if (old_where == c_IDLE || m_where == c_IDLE) begin
            m_fnd = 24'd0; m_sel = 1'b0;
        end else begin
            m_fnd = bus.i_src_data[old_cur*24 +: 24]; m_sel = bus.i_src_hm[old_cur];
        end
    endtask

    always @(posedge rst) model_reset();

    always @(posedge clk) begin
        if (!rst) begin
            model_step();
            #1;
            chk("m_idx",   32'(bus.o_src_idx),      32'(m_cur));
            chk("m_mode",  32'(bus.o_mode),         32'(m_mode));
            chk("m_alert", 32'(bus.o_alert_active), 32'(m_where == c_ALERT));
            chk("m_blank", 32'(bus.o_blank),        32'(m_where == c_IDLE));
            chk("m_fnd",   32'(bus.o_fnd_in_data),  32'(m_fnd));
            chk("m_sel",   32'(bus.o_sel_display),  32'(m_sel));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_next();
        bus.i_btn_next = 1'b1; @(negedge clk); bus.i_btn_next = 1'b0;
    endtask

    task automatic pulse_mode();
        bus.i_btn_mode = 1'b1; @(negedge clk); bus.i_btn_mode = 1'b0;
    endtask

    task automatic wait_idx(input int want, input int bound, output int at);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (int'(bus.o_src_idx) == want) begin at = cyc; return; end
        end
        chk("wait_idx_timeout", 32'(bus.o_src_idx), 32'(want));
        at = cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_blank"}, 32'(bus.o_blank),        32'd1);
        chk({tag, "_fnd"},   32'(bus.o_fnd_in_data),  32'd0);
        chk({tag, "_idx"},   32'(bus.o_src_idx),      32'd0);
        chk({tag, "_mode"},  32'(bus.o_mode),         32'd0);
        chk({tag, "_alert"}, 32'(bus.o_alert_active), 32'd0);
        chk({tag, "_sel"},   32'(bus.o_sel_display),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t3, t0, ta, tb_end;
        model_reset();
        bus.i_src_valid = 4'd0;
        bus.i_src_alert = 4'd0;
        bus.i_src_hm    = 4'b1010;
        bus.i_btn_next  = 1'b0;
        bus.i_btn_mode  = 1'b0;
        for (int k = 0; k < 4; k++) bus.i_src_data[24*k +: 24] = f_word(k);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        repeat (100) @(negedge clk);
        chk_reset_outputs("idle100");

        // 2: auto rotation over 0,1,3
        bus.i_src_valid = 4'b1011;
        wait_idx(1, 100, t1);
        @(negedge clk);
        chk("fnd_src1", 32'(bus.o_fnd_in_data), 32'(f_word(1)));
        chk("sel_src1", 32'(bus.o_sel_display), 32'd1);
        wait_idx(3, 100, t3);
        chk("dwell_1to3", 32'(t3 - t1), 32'd30);
        @(negedge clk);
        chk("fnd_src3", 32'(bus.o_fnd_in_data), 32'(f_word(3)));
        wait_idx(0, 100, t0);
        chk("dwell_3to0", 32'(t0 - t3), 32'd30);
        @(negedge clk);
        chk("fnd_src0", 32'(bus.o_fnd_in_data), 32'(f_word(0)));
        chk("sel_src0", 32'(bus.o_sel_display), 32'd0);

        // 3: manual mode and stepping
        pulse_mode();
        chk("mode_manual", 32'(bus.o_mode), 32'd1);
        repeat (200) @(negedge clk);
        chk("manual_frozen", 32'(bus.o_src_idx), 32'd0);
        pulse_next();
        chk("next_to1", 32'(bus.o_src_idx), 32'd1);
        pulse_next();
        chk("next_skip2", 32'(bus.o_src_idx), 32'd3);
        pulse_next();
        chk("next_wrap0", 32'(bus.o_src_idx), 32'd0);

        // 4: alert pre-emption
        bus.i_src_alert = 4'b1000;
        @(negedge clk);
        ta = cyc;
        chk("alert_on", 32'(bus.o_alert_active), 32'd1);
        chk("alert_idx", 32'(bus.o_src_idx), 32'd3);
        pulse_next();
        chk("alert_ign_next", 32'(bus.o_src_idx), 32'd3);
        tb_end = ta;
        for (int i = 0; i < 80 && bus.o_alert_active; i++) begin
            @(negedge clk);
            tb_end = cyc;
        end
        chk("alert_off", 32'(bus.o_alert_active), 32'd0);
        chk("alert_len_ok", 32'((tb_end - ta) >= 41 && (tb_end - ta) <= 50), 32'd1);
        chk("alert_idx_kept", 32'(bus.o_src_idx), 32'd3);
        repeat (100) @(negedge clk);
        chk("alert_no_retrig", 32'(bus.o_alert_active), 32'd0);
        bus.i_src_alert = 4'd0;

        // 5: losing sources
        pulse_next();
        pulse_next();
        chk("at_idx1", 32'(bus.o_src_idx), 32'd1);
        bus.i_src_valid = 4'b1001;
        @(negedge clk);
        chk("drop1_idx", 32'(bus.o_src_idx), 32'd3);
        bus.i_src_valid = 4'b0000;
        @(negedge clk);
        chk("none_blank", 32'(bus.o_blank), 32'd1);
        chk("none_fnd", 32'(bus.o_fnd_in_data), 32'd0);
        bus.i_src_valid = 4'b0100;
        @(negedge clk);
        chk("src2_idx", 32'(bus.o_src_idx), 32'd2);
        chk("src2_blank", 32'(bus.o_blank), 32'd0);
        @(negedge clk);
        chk("src2_fnd", 32'(bus.o_fnd_in_data), 32'(f_word(2)));

        // 6: asynchronous reset during an alert
        bus.i_src_alert = 4'b0100;
        @(negedge clk);
        chk("alert2_on", 32'(bus.o_alert_active), 32'd1);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        bus.i_src_alert = 4'd0;
        bus.i_src_valid = 4'd0;
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_idle", 32'(bus.o_blank), 32'd1);
        bus.i_src_valid = 4'b0001;
        @(negedge clk);
        chk("post_rst_show", 32'(bus.o_blank), 32'd0);
        @(negedge clk);
        chk("post_rst_fnd", 32'(bus.o_fnd_in_data), 32'(f_word(0)));

        // random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(39) == 0) bus.i_src_valid = 4'($urandom);
            if ($urandom_range(29) == 0) bus.i_src_alert[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(49) == 0) bus.i_src_hm = 4'($urandom);
            if ($urandom_range(7) == 0) bus.i_src_data[24*$urandom_range(3) +: 24] = 24'($urandom);
            bus.i_btn_next = ($urandom_range(24) == 0);
            bus.i_btn_mode = ($urandom_range(59) == 0);
        end
        @(negedge clk);
        bus.i_btn_next = 1'b0;
        bus.i_btn_mode = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
